// File: rtl/accel_sched_pkg.sv
// Shared state encoding, lane-count helper and timing defaults for the
// accelerator window scheduler and its bench.
package accel_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } sched_state_t;

    localparam int unsigned DEFAULT_START_GUARD    = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

    function automatic int unsigned lane_count(input int unsigned kernel_size);
        return kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/sched_wait_timer.sv
// Guard down-counter and timeout up-counter for the scheduler WAIT state.
module sched_wait_timer #(
    parameter int unsigned START_GUARD    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic tick,
    output logic guard_done,
    output logic timed_out
);

    localparam int unsigned GW = (START_GUARD > 0) ? $clog2(START_GUARD + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GW-1:0] GUARD_INIT = GW'(START_GUARD);
    localparam logic [TW-1:0] TIME_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [GW-1:0] guard;
    logic [TW-1:0] elapsed;

    // elapsed counts WAIT cycles already spent; timed_out marks the last allowed one
    always_ff @(posedge Clk) begin
        if (Rst) begin
            guard   <= '0;
            elapsed <= '0;
        end else if (clear) begin
            guard   <= GUARD_INIT;
            elapsed <= '0;
        end else if (tick) begin
            if (guard != '0)
                guard <= guard - GW'(1);
            if (!timed_out)
                elapsed <= elapsed + TW'(1);
        end
    end

    assign guard_done = (guard == '0);
    assign timed_out  = (elapsed == TIME_LIMIT);

endmodule

// File: rtl/accel_window_scheduler.sv
// Sequences one K x K window at a time through the multiplier array and
// returns the adder-tree sum on a valid/ready result port.
module accel_window_scheduler
    import accel_sched_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned AXI_BUS_WIDTH  = 32,
    parameter int unsigned START_GUARD    = DEFAULT_START_GUARD,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned IDX_WIDTH      = 16,
    localparam int unsigned N             = lane_count(KERNEL_SIZE)
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       kernel_load,
    input  logic [N*AXI_BUS_WIDTH-1:0] kernel_data,
    input  logic                       win_valid,
    output logic                       win_ready,
    input  logic [N*AXI_BUS_WIDTH-1:0] win_data,
    output logic [N*AXI_BUS_WIDTH-1:0] acc_multiplier,
    output logic [N*AXI_BUS_WIDTH-1:0] acc_multiplicand,
    output logic [N-1:0]               acc_mStart,
    input  logic                       acc_finalReady,
    input  logic [AXI_BUS_WIDTH-1:0]   acc_finalAccumulate,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [AXI_BUS_WIDTH-1:0]   res_data,
    output logic [IDX_WIDTH-1:0]       res_index,
    output logic                       busy,
    output logic                       timeout_err
);

    sched_state_t                 state;
    logic                         kernel_valid;
    logic [N*AXI_BUS_WIDTH-1:0]   kernel_reg;
    logic [N*AXI_BUS_WIDTH-1:0]   window_reg;
    logic                         guard_done;
    logic                         timed_out;

    sched_wait_timer #(
        .START_GUARD    (START_GUARD),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .Clk        (Clk),
        .Rst        (Rst),
        .clear      (state == ISSUE),
        .tick       (state == WAIT),
        .guard_done (guard_done),
        .timed_out  (timed_out)
    );

    // A kernel load in the same IDLE cycle takes priority over the window
    assign win_ready        = (state == IDLE) && kernel_valid && !kernel_load;
    assign acc_multiplier   = kernel_reg;
    assign acc_multiplicand = window_reg;
    assign res_valid        = (state == HOLD);
    assign busy             = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            kernel_valid <= 1'b0;
            kernel_reg   <= '0;
            window_reg   <= '0;
            acc_mStart   <= '0;
            res_data     <= '0;
            res_index    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            acc_mStart <= '0;
            case (state)
                IDLE: begin
                    if (kernel_load) begin
                        kernel_reg   <= kernel_data;
                        kernel_valid <= 1'b1;
                    end else if (win_valid && kernel_valid) begin
                        window_reg <= win_data;
                        acc_mStart <= '1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    // capture is checked first so it wins over a coincident timeout
                    if (guard_done && acc_finalReady) begin
                        res_data <= acc_finalAccumulate;
                        state    <= HOLD;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_index <= res_index + IDX_WIDTH'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_window_scheduler.sv
// Directed bench for accel_window_scheduler with an accelerator stand-in and a
// cycle-level behavioural model compared against the DUT every cycle.
module tb_accel_window_scheduler;
    import accel_sched_pkg::*;

    localparam int unsigned K  = 3;
    localparam int unsigned W  = 32;
    localparam int unsigned IW = 16;
    localparam int unsigned N  = lane_count(K);
    localparam int unsigned CW = N * W;
    localparam int SG = DEFAULT_START_GUARD;
    localparam int TO = DEFAULT_TIMEOUT_CYCLES;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          kernel_load = 1'b0;
    logic [CW-1:0] kernel_data = '0;
    logic          win_valid = 1'b0;
    logic          win_ready;
    logic [CW-1:0] win_data = '0;
    logic [CW-1:0] acc_multiplier;
    logic [CW-1:0] acc_multiplicand;
    logic [N-1:0]  acc_mStart;
    logic          acc_finalReady = 1'b0;
    logic [W-1:0]  acc_finalAccumulate = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic [IW-1:0] res_index;
    logic          busy;
    logic          timeout_err;

    accel_window_scheduler #(
        .KERNEL_SIZE    (K),
        .AXI_BUS_WIDTH  (W),
        .START_GUARD    (DEFAULT_START_GUARD),
        .TIMEOUT_CYCLES (DEFAULT_TIMEOUT_CYCLES),
        .IDX_WIDTH      (IW)
    ) dut (
        .Clk                 (Clk),
        .Rst                 (Rst),
        .kernel_load         (kernel_load),
        .kernel_data         (kernel_data),
        .win_valid           (win_valid),
        .win_ready           (win_ready),
        .win_data            (win_data),
        .acc_multiplier      (acc_multiplier),
        .acc_multiplicand    (acc_multiplicand),
        .acc_mStart          (acc_mStart),
        .acc_finalReady      (acc_finalReady),
        .acc_finalAccumulate (acc_finalAccumulate),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data),
        .res_index           (res_index),
        .busy                (busy),
        .timeout_err         (timeout_err)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    bit mdl_on = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (acc_mStart != '0) pulses++;

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] lanes_const(input logic [W-1:0] v);
        logic [CW-1:0] r;
        for (int n = 0; n < int'(N); n++) r[n*W +: W] = v;
        return r;
    endfunction

    function automatic logic [CW-1:0] lanes_seq();
        logic [CW-1:0] r;
        for (int n = 0; n < int'(N); n++) r[n*W +: W] = W'(n + 1);
        return r;
    endfunction

    function automatic logic [W-1:0] lane_dot(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic signed [W-1:0] s;
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        s = '0;
        for (int n = 0; n < int'(N); n++) begin
            x = a[n*W +: W];
            y = b[n*W +: W];
            s = s + x * y;
        end
        return s;
    endfunction

    // Accelerator stand-in: finalReady appears L+2 cycles after the start cycle
    int acc_L = 3;
    bit acc_stale = 1'b0;
    bit acc_never = 1'b0;
    int acc_cnt = 0;
    logic [W-1:0] acc_next = '0;

    always @(posedge Clk) begin
        if (Rst) begin
            acc_cnt             <= 0;
            acc_finalReady      <= 1'b0;
            acc_finalAccumulate <= '0;
        end else if (acc_mStart != '0) begin
            acc_next <= lane_dot(acc_multiplier, acc_multiplicand);
            acc_cnt  <= acc_never ? 0 : acc_L + 1;
            if (!acc_stale) acc_finalReady <= 1'b0;
        end else if (acc_cnt > 0) begin
            acc_cnt <= acc_cnt - 1;
            if (acc_cnt == 1) begin
                acc_finalReady      <= 1'b1;
                acc_finalAccumulate <= acc_next;
            end
        end
    end

    // Behavioural model: phase is derived from the accept cycle number
    bit            m_kvalid = 1'b0;
    bit            m_flight = 1'b0;
    bit            m_pending = 1'b0;
    bit            m_terr = 1'b0;
    logic [CW-1:0] m_kernel = '0;
    logic [CW-1:0] m_win = '0;
    logic [W-1:0]  m_res = '0;
    logic [W-1:0]  m_sum = '0;
    logic [IW-1:0] m_idx = '0;
    int            m_acc_cyc = 0;

    always @(negedge Clk) begin
        bit idle;
        int w;
        idle = !m_flight && !m_pending;
        if (mdl_on) begin
            check("win_ready", win_ready, idle && m_kvalid && !kernel_load);
            check("busy", busy, !idle);
            check("mStart", acc_mStart, (m_flight && cyc == m_acc_cyc + 1) ? CW'({N{1'b1}}) : '0);
            check("res_valid", res_valid, m_pending);
            check("res_data", res_data, m_res);
            check("res_index", res_index, m_idx);
            check("timeout_err", timeout_err, m_terr);
            check("multiplier", acc_multiplier, m_kernel);
            check("multiplicand", acc_multiplicand, m_win);
        end
        if (Rst) begin
            m_kvalid = 0; m_flight = 0; m_pending = 0; m_terr = 0;
            m_kernel = '0; m_win = '0; m_res = '0; m_idx = '0;
        end else if (m_pending) begin
            if (res_ready) begin
                m_pending = 0;
                m_idx = m_idx + 1'b1;
            end
        end else if (m_flight) begin
            w = cyc - m_acc_cyc - 1;
            if (w >= 1) begin
                if (w - 1 >= SG && acc_finalReady) begin
                    check("capture_sum", acc_finalAccumulate, m_sum);
                    m_res = acc_finalAccumulate;
                    m_pending = 1;
                    m_flight = 0;
                end else if (w >= TO) begin
                    m_terr = 1;
                    m_flight = 0;
                end
            end
        end else if (kernel_load) begin
            m_kvalid = 1;
            m_kernel = kernel_data;
        end else if (win_valid && m_kvalid) begin
            m_win = win_data;
            m_sum = lane_dot(m_kernel, win_data);
            m_flight = 1;
            m_acc_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_kernel(input logic [CW-1:0] v);
        kernel_load = 1'b1;
        kernel_data = v;
        step();
        kernel_load = 1'b0;
    endtask

    task automatic send_window(input logic [CW-1:0] v, output int acc_c);
        bit done;
        done = 1'b0;
        acc_c = 0;
        win_valid = 1'b1;
        win_data = v;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Clk);
            if (win_ready) begin
                done = 1'b1;
                acc_c = cyc;
            end
            step();
        end
        win_valid = 1'b0;
        check("win_accept", done, 1'b1);
    endtask

    task automatic wait_result(output int r);
        bit found;
        found = 1'b0;
        r = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge Clk);
            if (res_valid) begin
                found = 1'b1;
                r = cyc;
            end
        end
        check("result_seen", found, 1'b1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        int c;
        int r;
        int seen;
        bit idle_back;

        // reset
        @(posedge Clk);
        #1;
        mdl_on = 1'b1;
        step();
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_win_ready", win_ready, 1'b0);
        check("rst_res_index", res_index, '0);
        check("rst_busy", busy, 1'b0);
        step();

        // kernel of ones, window 1..9, L=3
        load_kernel(lanes_const(32'd1));
        pulses = 0;
        send_window(lanes_seq(), c);
        wait_result(r);
        check("t1_latency", r - c, 7);
        check("t1_sum", res_data, 32'd45);
        check("t1_index", res_index, '0);
        check("t1_pulses", pulses, 1);
        step();
        consume();

        // stale finalReady held high, L=1: guard must hide the old sum
        acc_stale = 1'b1;
        acc_L = 1;
        send_window(lanes_const(32'd2), c);
        wait_result(r);
        check("t2_latency", r - c, 5);
        check("t2_sum", res_data, 32'd18);
        check("t2_index", res_index, 16'd1);
        step();
        consume();
        acc_stale = 1'b0;
        acc_L = 3;

        // negative kernel, consumer stalls 10 cycles, kernel load during HOLD ignored
        load_kernel(lanes_const(32'hFFFF_FFFE));
        send_window(lanes_const(32'd3), c);
        wait_result(r);
        check("t3_sum", res_data, 32'hFFFF_FFCA);
        step();
        for (int i = 0; i < 10; i++) begin
            kernel_load = (i == 3);
            kernel_data = lanes_const(32'd7);
            @(negedge Clk);
            check("t3_hold_valid", res_valid, 1'b1);
            check("t3_hold_data", res_data, 32'hFFFF_FFCA);
            step();
        end
        kernel_load = 1'b0;
        consume();
        @(negedge Clk);
        check("t3_idle", busy, 1'b0);
        check("t3_kernel_kept", acc_multiplier, lanes_const(32'hFFFF_FFFE));
        step();

        // accelerator never answers: timeout after TO wait cycles
        acc_never = 1'b1;
        send_window(lanes_const(32'd5), c);
        seen = 0;
        idle_back = 1'b0;
        r = 0;
        for (int i = 0; i < 100 && !idle_back; i++) begin
            @(negedge Clk);
            if (res_valid) seen++;
            if (!busy) begin
                idle_back = 1'b1;
                r = cyc;
            end
        end
        check("t4_back_idle", idle_back, 1'b1);
        check("t4_abort_cycle", r - c, TO + 2);
        check("t4_no_result", seen, 0);
        check("t4_timeout_err", timeout_err, 1'b1);
        step();
        acc_never = 1'b0;
        send_window(lanes_const(32'd1), c);
        wait_result(r);
        check("t4_next_sum", res_data, 32'hFFFF_FFEE);
        check("t4_err_sticky", timeout_err, 1'b1);
        step();
        consume();

        // kernel load and window in the same cycle: kernel wins
        kernel_load = 1'b1;
        kernel_data = lanes_const(32'd2);
        win_valid = 1'b1;
        win_data = lanes_seq();
        @(negedge Clk);
        check("t5_ready_blocked", win_ready, 1'b0);
        step();
        kernel_load = 1'b0;
        send_window(lanes_seq(), c);
        wait_result(r);
        check("t5_new_kernel_sum", res_data, 32'd90);
        step();
        consume();

        // reset during WAIT
        send_window(lanes_seq(), c);
        step();
        step();
        @(negedge Clk);
        check("t6_in_wait", busy, 1'b1);
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        @(negedge Clk);
        check("t6_busy", busy, 1'b0);
        check("t6_res_valid", res_valid, 1'b0);
        check("t6_res_data", res_data, '0);
        check("t6_res_index", res_index, '0);
        check("t6_timeout_err", timeout_err, 1'b0);
        check("t6_kernel_clr", acc_multiplier, '0);
        step();
        win_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("t6_no_kernel_ready", win_ready, 1'b0);
            step();
        end
        win_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
